// File: rtl/data_sram_if.sv
// Data SRAM bus: zero-wait-state word access driven by the CPU side.
interface data_sram_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_resp.sv
// Data SRAM responder: word RAM plus a memory-mapped config window
// (LED, switches, seven-segment number, write counter, free-running timer).
module data_sram_resp #(
  parameter int unsigned RAM_AW    = 10,
  parameter logic [15:0] CONF_BASE = 16'hbfaf
) (
  input  logic             clk,
  input  logic             resetn,
  data_sram_if.slave       data_sram,
  input  logic [7:0]       switch,
  output logic [15:0]      led,
  output logic [31:0]      num_data
);

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1 << RAM_AW;

  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_SWITCH = 16'hF004;
  localparam logic [15:0] OFF_NUM    = 16'hF010;
  localparam logic [15:0] OFF_WRCNT  = 16'hF020;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;

  logic [DW-1:0]     ram [DEPTH];
  logic [15:0]       led_q;
  logic [DW-1:0]     num_q;
  logic [DW-1:0]     timer_q;
  logic [DW-1:0]     wrcnt_q;

  logic              conf_hit;
  logic [15:0]       conf_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_byte_bits;

  assign conf_hit         = (data_sram.addr[31:16] == CONF_BASE);
  assign conf_off         = {data_sram.addr[15:2], 2'b00};
  assign ram_idx          = data_sram.addr[RAM_AW+1:2];
  assign unused_byte_bits = ^data_sram.addr[1:0];

  // RAM is intentionally not reset; contents survive resetn.
  always_ff @(posedge clk) begin
    if (resetn && data_sram.we && !conf_hit) begin
      ram[ram_idx] <= data_sram.wdata;
    end
  end

  // Config registers; a timer write replaces that cycle's increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q   <= 16'hFFFF;
      num_q   <= '0;
      timer_q <= '0;
      wrcnt_q <= '0;
    end else begin
      if (data_sram.we) begin
        wrcnt_q <= wrcnt_q + DW'(1);
      end
      if (data_sram.we && conf_hit && conf_off == OFF_TIMER) begin
        timer_q <= data_sram.wdata;
      end else begin
        timer_q <= timer_q + DW'(1);
      end
      if (data_sram.we && conf_hit && conf_off == OFF_LED) begin
        led_q <= data_sram.wdata[15:0];
      end
      if (data_sram.we && conf_hit && conf_off == OFF_NUM) begin
        num_q <= data_sram.wdata;
      end
    end
  end

  // Combinational read shows pre-write state in a write cycle.
  always_comb begin
    data_sram.rdata = '0;
    if (conf_hit) begin
      case (conf_off)
        OFF_LED:    data_sram.rdata = {16'h0, led_q};
        OFF_SWITCH: data_sram.rdata = {24'h0, switch};
        OFF_NUM:    data_sram.rdata = num_q;
        OFF_WRCNT:  data_sram.rdata = wrcnt_q;
        OFF_TIMER:  data_sram.rdata = timer_q;
        default:    data_sram.rdata = '0;
      endcase
    end else begin
      data_sram.rdata = ram[ram_idx];
    end
  end

  assign led      = led_q;
  assign num_data = num_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: vector table plus timer and async-reset sequences.
module tb_data_sram_resp;
  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num_data;
  int          checks = 0;
  int          failures = 0;

  data_sram_if bus ();

  always #5 clk = ~clk;

  data_sram_resp #(.RAM_AW(10), .CONF_BASE(16'hbfaf)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .data_sram (bus),
    .switch    (switch),
    .led       (led),
    .num_data  (num_data)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
    logic [31:0] exp_num;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.we    = we;
    bus.addr  = addr;
    bus.wdata = wdata;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0,          16'hFFFF, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111, 16'hFFFF, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'hFFFF, 32'h0};
    vecs[3]  = '{1'b0, 32'h1C00_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'hFFFF, 32'h0};
    vecs[4]  = '{1'b0, 32'hBFAF_F000, 32'h0,         1'b1, 32'h0000_FFFF, 16'hFFFF, 32'h0};
    vecs[5]  = '{1'b1, 32'hBFAF_F000, 32'h1234_5A5A, 1'b1, 32'h0000_FFFF, 16'hFFFF, 32'h0};
    vecs[6]  = '{1'b0, 32'hBFAF_F000, 32'h0,         1'b1, 32'h0000_5A5A, 16'h5A5A, 32'h0};
    vecs[7]  = '{1'b1, 32'hBFAF_F010, 32'hCAFE_F00D, 1'b1, 32'h0,          16'h5A5A, 32'h0};
    vecs[8]  = '{1'b0, 32'hBFAF_F010, 32'h0,         1'b1, 32'hCAFE_F00D, 16'h5A5A, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 32'hBFAF_F004, 32'h0,         1'b1, 32'h0000_00A5, 16'h5A5A, 32'hCAFE_F00D};
    vecs[10] = '{1'b1, 32'hBFAF_F004, 32'h0,         1'b1, 32'h0000_00A5, 16'h5A5A, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 32'hBFAF_1234, 32'h77,        1'b1, 32'h0,          16'h5A5A, 32'hCAFE_F00D};
    vecs[12] = '{1'b0, 32'hBFAF_1234, 32'h0,         1'b1, 32'h0,          16'h5A5A, 32'hCAFE_F00D};
    vecs[13] = '{1'b0, 32'hBFAF_F020, 32'h0,         1'b1, 32'h0000_0006, 16'h5A5A, 32'hCAFE_F00D};
    vecs[14] = '{1'b0, 32'hBFAF_F013, 32'h0,         1'b1, 32'hCAFE_F00D, 16'h5A5A, 32'hCAFE_F00D};
    vecs[15] = '{1'b0, 32'h0000_1010, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'h5A5A, 32'hCAFE_F00D};

    // Reset held: writes ignored, timer and write counter frozen at zero.
    resetn = 1'b0;
    switch = 8'hA5;
    drive(1'b1, 32'hBFAF_F000, 32'h0000_1234);
    @(negedge clk);
    check("rst_led", 32'(led), 32'h0000_FFFF);
    check("rst_num", num_data, 32'h0);
    bus.addr = 32'hBFAF_E000;
    #1 check("rst_timer", bus.rdata, 32'h0);
    bus.addr = 32'hBFAF_F020;
    #1 check("rst_wrcnt", bus.rdata, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_led_hold", 32'(led), 32'h0000_FFFF);
    bus.addr = 32'hBFAF_E000;
    #1 check("rst_timer_hold", bus.rdata, 32'h0);

    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 32'hBFAF_E000, 32'h0);
    @(negedge clk);
    #1 check("timer_first_edge", bus.rdata, 32'h1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
      check($sformatf("vec%0d_num", i), num_data, vecs[i].exp_num);
    end

    // Timer load suppresses that cycle's increment, then wraps.
    @(negedge clk);
    drive(1'b1, 32'hBFAF_E000, 32'hFFFF_FFFE);
    @(negedge clk);
    drive(1'b0, 32'hBFAF_E000, 32'h0);
    #1 check("timer_load", bus.rdata, 32'hFFFF_FFFE);
    @(negedge clk);
    #1 check("timer_max", bus.rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    #1 check("timer_wrap", bus.rdata, 32'h0);

    // Asynchronous reset between edges; RAM keeps its contents.
    @(negedge clk);
    drive(1'b1, 32'hBFAF_F000, 32'h0000_0001);
    @(negedge clk);
    drive(1'b1, 32'hBFAF_E000, 32'd500);
    @(negedge clk);
    drive(1'b0, 32'hBFAF_E000, 32'h0);
    #1 check("pre_arst_led", 32'(led), 32'h0000_0001);
    check("pre_arst_timer", bus.rdata, 32'd500);
    #1 resetn = 1'b0;
    #1 check("arst_led", 32'(led), 32'h0000_FFFF);
    check("arst_timer", bus.rdata, 32'h0);
    check("arst_num", num_data, 32'h0);
    bus.addr = 32'h0000_0010;
    #1 check("arst_ram_kept", bus.rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
